// File: rtl/uart_pkg.sv
// Shared FSM state type and default command/response byte codes for the
// UART register bridge.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        REG_WR,
        REG_RD,
        RD_WAIT,
        SEND
    } bridge_state_t;

    localparam logic [7:0] UART_CMD_WR  = 8'h57;  // 'W'
    localparam logic [7:0] UART_CMD_RD  = 8'h52;  // 'R'
    localparam logic [7:0] UART_RSP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] UART_RSP_ERR = 8'h45;  // 'E'

    // States in which the bridge is willing to pop a byte from the RX FIFO.
    function automatic logic accepts_byte(input bridge_state_t s);
        return (s == IDLE) || (s == GET_ADDR) || (s == GET_DATA);
    endfunction

endpackage

// File: rtl/uart_reg_bridge.sv
// Serial command engine: parses 'W' addr data / 'R' addr frames from the UART
// RX FIFO, drives a local register bus and answers through the TX FIFO.
// Optional inter-byte timeout: define UART_REG_BRIDGE_TIMEOUT_EN.
module uart_reg_bridge
    import uart_pkg::*;
#(
    parameter int         ADDR_W  = 8,
    parameter logic [7:0] CMD_WR  = UART_CMD_WR,
    parameter logic [7:0] CMD_RD  = UART_CMD_RD,
    parameter logic [7:0] RSP_OK  = UART_RSP_OK,
    parameter logic [7:0] RSP_ERR = UART_RSP_ERR,
    parameter int         TIMEOUT = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata
);

    bridge_state_t state;
    logic          is_write;
    logic [7:0]    rsp;
    logic          timeout_hit;

    // Pop is gated by reset so no byte is consumed while reset is held.
    assign rd_uart = accepts_byte(state) && !rx_empty && !reset;
    assign wr_uart = (state == SEND) && !tx_full;
    assign w_data  = rsp;
    assign reg_we  = (state == REG_WR);
    assign reg_re  = (state == REG_RD);

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] idle_cnt;
    logic             waiting;

    assign waiting     = ((state == GET_ADDR) || (state == GET_DATA)) && rx_empty;
    // Fires on the cycle the counter reaches TIMEOUT, so the FSM leaves at once.
    assign timeout_hit = waiting &&
                         (({1'b0, idle_cnt} + (CNT_W + 1)'(1)) >= {1'b0, CNT_MAX});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (rd_uart || !((state == GET_ADDR) || (state == GET_DATA))) begin
            idle_cnt <= '0;
        end else if (idle_cnt != CNT_MAX) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            rsp       <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_uart) begin
                        if (r_data == CMD_WR) begin
                            is_write <= 1'b1;
                            state    <= GET_ADDR;
                        end else if (r_data == CMD_RD) begin
                            is_write <= 1'b0;
                            state    <= GET_ADDR;
                        end else begin
                            rsp   <= RSP_ERR;
                            state <= SEND;
                        end
                    end
                end
                GET_ADDR: begin
                    if (rd_uart) begin
                        reg_addr <= r_data[ADDR_W-1:0];
                        state    <= is_write ? GET_DATA : REG_RD;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end
                end
                GET_DATA: begin
                    if (rd_uart) begin
                        reg_wdata <= r_data;
                        state     <= REG_WR;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end
                end
                REG_WR: begin
                    rsp   <= RSP_OK;
                    state <= SEND;
                end
                REG_RD: begin
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    rsp   <= reg_rdata;
                    state <= SEND;
                end
                SEND: begin
                    if (!tx_full) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
